axis_i2c_cmd_fifo: RTL

- Command buffer directly upstream of the I2C serialiser.
- Accepts I2C transfer words {data, rw, addr} from a host-side AXI-Stream master and holds them in a synchronous FIFO.
- Presents them one at a time, first-word-fall-through, on an AXI-Stream master port. The serialiser's late tready (asserted one cycle after it samples tvalid) never loses or corrupts a word.
- Provides a synchronous flush and occupancy/status outputs for the host.

---
 rtl/axis_i2c_cmd_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/axis_i2c_cmd_fifo.sv
// First-word-fall-through command FIFO between the host AXI-Stream master and the I2C serialiser.
// Full and empty come from an occupancy counter, so the pointers are free to wrap.
module axis_i2c_cmd_fifo #(
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int DEPTH           = 8,
  parameter int AFULL_LEVEL     = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       flush,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       afull,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AXIS_DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          live_q;
  logic          wrEn, rdEn;

  // Ready depends only on registered state and flush, never on m_axis_tready,
  // so a pop in a full cycle cannot open a same-cycle write.
  assign s_axis_tready = live_q & (count_q < CW'(DEPTH)) & ~flush;
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem[rdPtr_q];
  assign count         = count_q;
  assign afull         = (count_q >= CW'(AFULL_LEVEL));
  assign empty         = (count_q == '0);

  assign wrEn = s_axis_tvalid & s_axis_tready;
  assign rdEn = m_axis_tvalid & m_axis_tready;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrEn) wrPtr_d = wrPtr_q + AW'(1);
      if (rdEn) rdPtr_d = rdPtr_q + AW'(1);
      if (wrEn && !rdEn)      count_d = count_q + CW'(1);
      else if (rdEn && !wrEn) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      live_q  <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      live_q  <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q] <= s_axis_tdata;
  end

endmodule
